data_ram: RTL and testbench
===========================

// Module: data_ram
// PURPOSE
//  - Word-addressed data memory for the miniARMv7 core: one synchronous write port, one combinational read port.
//  - Serves processor load/store traffic.
//  - Read and write use independent addresses, so both can occur in the same cycle.
// PARAMETERS
//  - DATA_W  32  width of each memory word and of io_dataR/io_dataW
//  - ADDR_W  10  index bits actually decoded; depth = 2**ADDR_W words (1024)
// PORTS
//  - clock     in   1       single clock; all state updates on the rising edge
//  - reset     in   1       synchronous, active-high reset
//  - io_wEN    in   1       write enable
//  - io_rEN    in   1       read enable
//  - io_addrR  in   32      read word index (not a byte address)
//  - io_addrW  in   32      write word index (not a byte address)
//  - io_dataW  in   DATA_W  write data
//  - io_dataR  out  DATA_W  read data
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is synchronous and active-high.
//  - Storage: array mem[0 .. 2**ADDR_W-1] of DATA_W bits.
//  - Contents are not cleared by reset; unwritten words read as X in simulation.
//  - Addressing: only bits [ADDR_W-1:0] of io_addrR and io_addrW are decoded.
//    - Upper bits are ignored, so addresses wrap: address 2**ADDR_W aliases word 0.
//  - Write: at a rising edge with reset==0 and io_wEN==1, mem[io_addrW] <= io_dataW.
//    - While reset==1, writes are suppressed.
//    - Write latency is 1 cycle: the new value is visible on the read port in the cycle after the edge.
//  - Read: combinational, zero latency.
//    - io_rEN==1 and reset==0: io_dataR = mem[io_addrR].
//    - Otherwise: io_dataR = 0.
//    - io_dataR follows io_addrR changes within the same cycle; there is no output register.
//  - Reset value of outputs: io_dataR = 0 for every cycle reset is high.
//  - Simultaneous read and write, different addresses: fully independent.
//  - Simultaneous read and write, same address: read returns the OLD contents until the edge, then the new value.
//    - The RAM_BYPASS_EN build changes this case; see CONFIGURATION.
//  - Repeated writes to the same address: the last write wins.
//  - Reset asserted mid-operation:
//    - A write on an edge where reset==1 is dropped.
//    - Previously stored words are preserved.
//  - No handshake, no stall, no error signalling; every request completes in its cycle.
// CONFIGURATION
//  - RAM_BYPASS_EN defined: write-to-read forwarding.
//    - Applies when io_wEN && io_rEN && !reset and addrR[ADDR_W-1:0] == addrW[ADDR_W-1:0].
//    - In that case io_dataR = io_dataW combinationally, in the same cycle as the write.
//  - RAM_BYPASS_EN undefined: no forwarding; the same-address case returns the old contents as described above.
// TESTING
//  - Reset: reset=1 for 1 cycle with io_rEN=1 -> io_dataR==0; then reset=0.
//  - Write then read: write addrW=0 dataW=123 for 2 cycles; then rEN=1 addrR=0 -> io_dataR==123.
//    - Repeat with addrW=1 dataW=456; read addrR=1 -> io_dataR==456.
//  - Same-address write+read: wEN=1 rEN=1 addrW=addrR=2 dataW=789.
//    - Without RAM_BYPASS_EN: io_dataR==X/old before the first edge, 789 after it.
//    - With RAM_BYPASS_EN: io_dataR==789 immediately.
//  - Readback sweep: rEN=1, addrR=0,1,2 one cycle each -> io_dataR==123, 456, 789; rEN=0 -> io_dataR==0.
//  - Wrap and reset-blocked write:
//    - Write addrW=1024 dataW=55 -> read addrR=0 returns 55.
//    - Write addrW=3 dataW=9 while reset=1 -> addr 3 is left unwritten (still X/previous), never 9.

Source files
------------

// File: rtl/data_ram.sv
// Word-addressed data RAM: one synchronous write port and one combinational read port with independent addresses.
// Write data is visible on the read port one cycle after the write. Reads have zero latency. There is no backpressure.
// Optional build macro RAM_BYPASS_EN forwards io_dataW to io_dataR when both ports use the same address in the same cycle.
module data_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wEN,
    input  logic              io_rEN,
    input  logic [31:0]       io_addrR,
    input  logic [31:0]       io_addrW,
    input  logic [DATA_W-1:0] io_dataW,
    output logic [DATA_W-1:0] io_dataR
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_w;

    // Upper index bits are dropped, so addresses wrap modulo DEPTH.
    assign idx_r = io_addrR[ADDR_W-1:0];
    assign idx_w = io_addrW[ADDR_W-1:0];

    logic unused_addr_hi;
    assign unused_addr_hi = ^{io_addrR[31:ADDR_W], io_addrW[31:ADDR_W]};

    // Contents are not cleared by reset. Reset only blocks writes.
    always_ff @(posedge clock) begin
        if (!reset && io_wEN) begin
            mem[idx_w] <= io_dataW;
        end
    end

    always_comb begin
        io_dataR = '0;
        if (io_rEN && !reset) begin
`ifdef RAM_BYPASS_EN
            if (io_wEN && (idx_r == idx_w)) begin
                io_dataR = io_dataW;
            end else begin
                io_dataR = mem[idx_r];
            end
`else
            io_dataR = mem[idx_r];
`endif
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: expected read data is queued when stimulus is driven and is checked at the following falling edge.
module tb_data_ram;

    logic        clock;
    logic        reset;
    logic        io_wEN;
    logic        io_rEN;
    logic [31:0] io_addrR;
    logic [31:0] io_addrW;
    logic [31:0] io_dataW;
    logic [31:0] io_dataR;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    data_ram #(.DATA_W(32), .ADDR_W(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_wEN   (io_wEN),
        .io_rEN   (io_rEN),
        .io_addrR (io_addrR),
        .io_addrW (io_addrW),
        .io_dataW (io_dataW),
        .io_dataR (io_dataR)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle. The inputs are applied just after the rising edge. If chk is set, the read port is sampled at the falling edge.
    task automatic cyc(input logic rst, input logic wen, input logic ren,
                       input logic [31:0] aw, input logic [31:0] dw, input logic [31:0] ar,
                       input logic chk, input string tag, input logic [31:0] exp);
        exp_t e;
        reset    = rst;
        io_wEN   = wen;
        io_rEN   = ren;
        io_addrW = aw;
        io_dataW = dw;
        io_addrR = ar;
        if (chk) exp_q.push_back('{tag: tag, val: exp});
        @(negedge clock);
        if (chk) begin
            if (exp_q.size() == 0) begin
                check_eq("queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq(e.tag, io_dataR, e.val);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] aw, input logic [31:0] dw);
        cyc(1'b0, 1'b1, 1'b0, aw, dw, 32'd0, 1'b0, "", 32'd0);
    endtask

    task automatic rd(input logic [31:0] ar, input string tag, input logic [31:0] exp);
        cyc(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, ar, 1'b1, tag, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] same_exp;
        reset    = 1'b1;
        io_wEN   = 1'b0;
        io_rEN   = 1'b0;
        io_addrR = '0;
        io_addrW = '0;
        io_dataW = '0;
        @(posedge clock);
        #1;

        cyc(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, "reset_out", 32'd0);

        wr(32'd0, 32'd123);
        wr(32'd0, 32'd123);
        rd(32'd0, "read_a0", 32'd123);
        wr(32'd1, 32'd456);
        wr(32'd1, 32'd456);
        rd(32'd1, "read_a1", 32'd456);

        // Give address 2 a known old value so that the same-address case has a defined expectation.
        wr(32'd2, 32'h222);
        wr(32'd3, 32'h333);
`ifdef RAM_BYPASS_EN
        same_exp = 32'd789;
`else
        same_exp = 32'h222;
`endif
        cyc(1'b0, 1'b1, 1'b1, 32'd2, 32'd789, 32'd2, 1'b1, "same_addr_pre", same_exp);
        rd(32'd2, "same_addr_post", 32'd789);

        rd(32'd0, "sweep_a0", 32'd123);
        rd(32'd1, "sweep_a1", 32'd456);
        rd(32'd2, "sweep_a2", 32'd789);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, "ren_low", 32'd0);

        cyc(1'b0, 1'b1, 1'b1, 32'd4, 32'h44, 32'd1, 1'b1, "diff_addr_rd", 32'd456);
        rd(32'd4, "diff_addr_wr", 32'h44);

        wr(32'd1024, 32'd55);
        rd(32'd0, "wrap_write", 32'd55);
        rd(32'd1025, "wrap_read", 32'd456);

        cyc(1'b1, 1'b1, 1'b1, 32'd3, 32'd9, 32'd3, 1'b1, "reset_mid_out", 32'd0);
        rd(32'd3, "reset_blocked_wr", 32'h333);

        wr(32'd5, 32'd1);
        wr(32'd5, 32'd2);
        rd(32'd5, "last_write_wins", 32'd2);

        cyc(1'b0, 1'b1, 1'b0, 32'd6, 32'h66, 32'd6, 1'b1, "ren_low_wr_same", 32'd0);
        rd(32'd6, "wr_with_ren_low", 32'h66);

        if (exp_q.size() != 0) check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
